arbiter_1_to_n_response_engine: RTL and testbench

Distributes one shared stream of engine response packets to NUM_ENGINE_RECEIVER per-engine output queues, routing each packet by the destination engine id carried in its payload. It sits on the return path opposite the N-to-1 request arbiter: requests are merged toward memory or the next stage, and this block fans the responses back out to the originating engines. Each receiver drains its own FIFO with its own read enable. Upstream is throttled by a single registered ready.

---
 rtl/arbiter_1_to_n_response_engine_pkg.sv | 67 ++++++
 rtl/arbiter_1_to_n_response_engine_demux.sv | 63 ++++++
 rtl/arbiter_1_to_n_response_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_arbiter_1_to_n_response_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_1_to_n_response_engine_pkg.sv
// Shared packet and FIFO status types for the response fan-out engine.
package arbiter_1_to_n_response_engine_pkg;

  // Width of the destination engine id field carried in every payload.
  localparam int unsigned ENGINE_ID_FIELD_W = 8;
  localparam int unsigned ENGINE_DATA_W     = 32;

  typedef struct packed {
    logic [ENGINE_ID_FIELD_W-1:0] id_engine;
  } EngineRouteEndpoint;

  typedef struct packed {
    EngineRouteEndpoint to;
  } EngineRoute;

  typedef struct packed {
    EngineRoute route;
  } EngineMeta;

  typedef struct packed {
    EngineMeta                meta;
    logic [ENGINE_DATA_W-1:0] data;
  } EnginePacketPayload;

  typedef struct packed {
    logic               valid;
    EnginePacketPayload payload;
  } EnginePacket;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic full;
    logic empty;
    logic valid;
    logic prog_full;
  } FIFOStateSignalsOutput;

  typedef struct packed {
    logic full;
    logic empty;
    logic valid;
    logic prog_full;
    logic wr_rst_busy;
    logic rd_rst_busy;
  } FIFOStateSignalsInternal;

  localparam FIFOStateSignalsOutput FIFO_STATE_OUT_IDLE = '{
    full: 1'b0, empty: 1'b0, valid: 1'b0, prog_full: 1'b0
  };

  // Project the raw FIFO status onto the receiver-facing view; a read
  // beat is never reported while the queue is still coming out of reset.
  function automatic FIFOStateSignalsOutput map_internal_fifo_signals_to_output(
    input FIFOStateSignalsInternal s
  );
    FIFOStateSignalsOutput o;
    o.full      = s.full;
    o.empty     = s.empty;
    o.valid     = s.valid & ~(s.wr_rst_busy | s.rd_rst_busy);
    o.prog_full = s.prog_full;
    return o;
  endfunction

endpackage

// File: rtl/arbiter_1_to_n_response_engine_demux.sv
// Route decode: turns the destination id of a registered packet into a
// one-hot write strobe, or a drop flag when the id names no receiver.
module demux_bus_1_in_n_out
  import arbiter_1_to_n_response_engine_pkg::*;
#(
  parameter int NUM_OUT  = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic               ap_clk,
  input  logic               areset,
  input  logic               srst,
  input  logic               valid_in,
  input  EnginePacketPayload payload_in,
  output logic [NUM_OUT-1:0] wr_en_out,
  output EnginePacketPayload payload_out,
  output logic               drop_out
);

  localparam logic [ID_WIDTH:0] NUM_OUT_V = (ID_WIDTH+1)'(NUM_OUT);

  logic [ID_WIDTH-1:0] id_s;
  logic                in_range_s;
  logic [NUM_OUT-1:0]  onehot_s;
  logic                drop_s;
  logic [NUM_OUT-1:0]  wr_en_r;
  logic                drop_r;
  EnginePacketPayload  payload_r;

  // Decode the destination id into a one-hot strobe and an out-of-range flag.
  always_comb begin
    id_s       = payload_in.meta.route.to.id_engine[ID_WIDTH-1:0];
    in_range_s = ({1'b0, id_s} < NUM_OUT_V);
    onehot_s   = {NUM_OUT{1'b0}};
    for (int i = 0; i < NUM_OUT; i++) begin
      onehot_s[i] = valid_in & in_range_s & (id_s == ID_WIDTH'(i));
    end
    drop_s = valid_in & ~in_range_s;
  end

  // Register the strobes so the FIFO write happens one stage later.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      wr_en_r <= {NUM_OUT{1'b0}};
      drop_r  <= 1'b0;
    end else if (srst) begin
      wr_en_r <= {NUM_OUT{1'b0}};
      drop_r  <= 1'b0;
    end else begin
      wr_en_r <= onehot_s;
      drop_r  <= drop_s;
    end
  end

  // The payload travels alongside the strobes and needs no reset.
  always_ff @(posedge ap_clk) begin
    payload_r <= payload_in;
  end

  assign wr_en_out   = wr_en_r;
  assign drop_out    = drop_r;
  assign payload_out = payload_r;

endmodule

// File: rtl/arbiter_1_to_n_response_engine.sv
// Fans one stream of engine responses out to per-receiver queues, routed by
// the destination id in each payload, with a single registered ready upstream.
module arbiter_1_to_n_response_engine
  import arbiter_1_to_n_response_engine_pkg::*;
#(
  parameter int NUM_ENGINE_RECEIVER = 2,
  parameter int ID_WIDTH            = (NUM_ENGINE_RECEIVER > 1) ? $clog2(NUM_ENGINE_RECEIVER) : 1,
  parameter int FIFO_WRITE_DEPTH    = 16,
  parameter int PROG_THRESH         = 12
) (
  input  logic                                            ap_clk,
  input  logic                                            areset,
  input  EnginePacket                                     response_in,
  input  FIFOStateSignalsInput  [NUM_ENGINE_RECEIVER-1:0] fifo_response_signals_in,
  output FIFOStateSignalsOutput [NUM_ENGINE_RECEIVER-1:0] fifo_response_signals_out,
  output EnginePacket           [NUM_ENGINE_RECEIVER-1:0] response_out,
  output logic                                            response_ready_out,
  output logic [15:0]                                     drop_count_out,
  output logic                                            error_out,
  output logic                                            fifo_setup_signal
);

  localparam int N  = NUM_ENGINE_RECEIVER;
  localparam int AW = $clog2(FIFO_WRITE_DEPTH);
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(FIFO_WRITE_DEPTH);
  localparam logic [AW:0] THRESH_V = (AW+1)'(PROG_THRESH);

  logic [1:0]                   rst_sync_r;
  logic                         srst_s;
  logic                         in_valid_r;
  EnginePacketPayload           in_payload_r;
  logic [N-1:0]                 rd_req_r;
  logic [N-1:0]                 wr_en_v;
  EnginePacketPayload           wr_payload_s;
  logic                         drop_s;
  logic [N-1:0]                 full_v;
  logic [N-1:0]                 empty_v;
  logic [N-1:0]                 valid_v;
  logic [N-1:0]                 prog_full_v;
  logic [N-1:0]                 busy_v;
  EnginePacketPayload [N-1:0]   dout_v;
  FIFOStateSignalsInternal [N-1:0] fifo_int_s;
  FIFOStateSignalsOutput [N-1:0]   status_next_s;
  FIFOStateSignalsOutput [N-1:0]   status_r;
  logic [N-1:0]                 out_valid_r;
  EnginePacketPayload [N-1:0]   out_payload_r;
  logic                         ready_r;
  logic                         setup_r;
  logic [15:0]                  drop_cnt_r;
  logic                         error_r;

  // Two-flop release of the reset that feeds the queues' synchronous clear.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      rst_sync_r <= 2'b11;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b0};
    end
  end
  assign srst_s = rst_sync_r[1];

  // Stage 1: capture the incoming packet valid.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      in_valid_r <= 1'b0;
    end else if (srst_s) begin
      in_valid_r <= 1'b0;
    end else begin
      in_valid_r <= response_in.valid;
    end
  end

  // Stage 1 payload register, unreset.
  always_ff @(posedge ap_clk) begin
    in_payload_r <= response_in.payload;
  end

  // Capture each receiver's pop request.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      rd_req_r <= {N{1'b0}};
    end else if (srst_s) begin
      rd_req_r <= {N{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) begin
        rd_req_r[i] <= fifo_response_signals_in[i].rd_en;
      end
    end
  end

  demux_bus_1_in_n_out #(
    .NUM_OUT  (N),
    .ID_WIDTH (ID_WIDTH)
  ) u_demux (
    .ap_clk      (ap_clk),
    .areset      (areset),
    .srst        (srst_s),
    .valid_in    (in_valid_r),
    .payload_in  (in_payload_r),
    .wr_en_out   (wr_en_v),
    .payload_out (wr_payload_s),
    .drop_out    (drop_s)
  );

  generate
    for (genvar g = 0; g < N; g++) begin : g_fifo
      EnginePacketPayload mem_r [FIFO_WRITE_DEPTH];
      EnginePacketPayload dout_r;
      logic [AW-1:0]      wr_ptr_r;
      logic [AW-1:0]      rd_ptr_r;
      logic [AW:0]        count_r;
      logic               valid_r;
      logic               rst_busy_r;
      logic               empty_s;
      logic               wr_s;
      logic               rd_s;

      // Occupancy-derived flags and the guarded read/write strobes.
      always_comb begin
        empty_s = (count_r == {(AW+1){1'b0}});
        wr_s    = wr_en_v[g] & (count_r != DEPTH_V) & ~srst_s;
        rd_s    = ~empty_s & rd_req_r[g];
      end

      // Pointers, occupancy and read-valid; cleared by the synchronous reset.
      always_ff @(posedge ap_clk) begin
        if (srst_s) begin
          wr_ptr_r   <= {AW{1'b0}};
          rd_ptr_r   <= {AW{1'b0}};
          count_r    <= {(AW+1){1'b0}};
          valid_r    <= 1'b0;
          rst_busy_r <= 1'b1;
        end else begin
          rst_busy_r <= 1'b0;
          valid_r    <= rd_s;
          count_r    <= count_r + {{AW{1'b0}}, wr_s} - {{AW{1'b0}}, rd_s};
          if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
          end
          if (rd_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
          end
        end
      end

      // Storage array and first-word read register.
      always_ff @(posedge ap_clk) begin
        if (wr_s) begin
          mem_r[wr_ptr_r] <= wr_payload_s;
        end
        if (rd_s) begin
          dout_r <= mem_r[rd_ptr_r];
        end
      end

      assign full_v[g]      = (count_r == DEPTH_V);
      assign empty_v[g]     = empty_s;
      assign prog_full_v[g] = (count_r >= THRESH_V);
      assign valid_v[g]     = valid_r;
      assign busy_v[g]      = rst_busy_r;
      assign dout_v[g]      = dout_r;
    end
  endgenerate

  // Gather raw per-queue status and map it to the receiver-facing view.
  always_comb begin
    fifo_int_s    = {(N*$bits(FIFOStateSignalsInternal)){1'b0}};
    status_next_s = {(N*$bits(FIFOStateSignalsOutput)){1'b0}};
    for (int i = 0; i < N; i++) begin
      fifo_int_s[i].full        = full_v[i];
      fifo_int_s[i].empty       = empty_v[i];
      fifo_int_s[i].valid       = valid_v[i];
      fifo_int_s[i].prog_full   = prog_full_v[i];
      fifo_int_s[i].wr_rst_busy = busy_v[i];
      fifo_int_s[i].rd_rst_busy = busy_v[i];
      status_next_s[i]          = map_internal_fifo_signals_to_output(fifo_int_s[i]);
    end
  end

  // Registered status and delivery valids towards the receivers.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      out_valid_r <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        status_r[i] <= FIFO_STATE_OUT_IDLE;
      end
    end else begin
      out_valid_r <= valid_v;
      status_r    <= status_next_s;
    end
  end

  // Delivered payloads, unreset.
  always_ff @(posedge ap_clk) begin
    out_payload_r <= dout_v;
  end

  // Setup flag follows the queues' reset-busy; ready waits for setup and headroom.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      setup_r <= 1'b1;
      ready_r <= 1'b0;
    end else begin
      setup_r <= |busy_v;
      ready_r <= ~(|prog_full_v) & ~setup_r;
    end
  end

  // Saturating drop counter with sticky error.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      drop_cnt_r <= 16'h0000;
      error_r    <= 1'b0;
    end else if (srst_s) begin
      drop_cnt_r <= 16'h0000;
      error_r    <= 1'b0;
    end else if (drop_s) begin
      drop_cnt_r <= (drop_cnt_r == 16'hFFFF) ? 16'hFFFF : drop_cnt_r + 16'h0001;
      error_r    <= 1'b1;
    end
  end

  // Assemble the per-receiver packet outputs.
  always_comb begin
    response_out = {(N*$bits(EnginePacket)){1'b0}};
    for (int i = 0; i < N; i++) begin
      response_out[i].valid   = out_valid_r[i];
      response_out[i].payload = out_payload_r[i];
    end
  end

  assign fifo_response_signals_out = status_r;
  assign response_ready_out        = ready_r;
  assign drop_count_out            = drop_cnt_r;
  assign error_out                 = error_r;
  assign fifo_setup_signal         = setup_r;

endmodule

// File: tb/tb_arbiter_1_to_n_response_engine.sv
// Randomized bench for the response fan-out engine with a queue-based model.
module tb_arbiter_1_to_n_response_engine;
  import arbiter_1_to_n_response_engine_pkg::*;

  localparam int N      = 3;
  localparam int THRESH = 12;

  logic                         ap_clk = 1'b0;
  logic                         areset;
  EnginePacket                  response_in;
  FIFOStateSignalsInput  [N-1:0] rd_in;
  FIFOStateSignalsOutput [N-1:0] status_out;
  EnginePacket           [N-1:0] resp_out;
  logic                         ready;
  logic [15:0]                  drop_cnt;
  logic                         error;
  logic                         setup;

  always #5 ap_clk = ~ap_clk;

  arbiter_1_to_n_response_engine #(
    .NUM_ENGINE_RECEIVER (N),
    .FIFO_WRITE_DEPTH    (16),
    .PROG_THRESH         (THRESH)
  ) dut (
    .ap_clk                    (ap_clk),
    .areset                    (areset),
    .response_in               (response_in),
    .fifo_response_signals_in  (rd_in),
    .fifo_response_signals_out (status_out),
    .response_out              (resp_out),
    .response_ready_out        (ready),
    .drop_count_out            (drop_cnt),
    .error_out                 (error),
    .fifo_setup_signal         (setup)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          delivered = 0;
  bit          lat_chk = 1'b0;
  logic [15:0] drop_model = 16'h0000;
  logic [39:0] exp_q [N][$];
  int          iss_q [N][$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  // Advance one cycle, then score every delivered packet against the model.
  task automatic tick();
    logic [39:0] e;
    int          t;
    @(posedge ap_clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (resp_out[i].valid === 1'b1) begin
        delivered++;
        if (exp_q[i].size() == 0) begin
          check_eq($sformatf("unexpected_out%0d", i), 64'(resp_out[i].valid), 64'd0);
        end else begin
          e = exp_q[i].pop_front();
          t = iss_q[i].pop_front();
          check_eq($sformatf("payload%0d", i), 64'(resp_out[i].payload), 64'(e));
          if (lat_chk) check_eq($sformatf("latency%0d", i), 64'(cyc - t), 64'd5);
        end
      end
    end
  endtask

  // Offer one packet this cycle if wanted and ready is high.
  task automatic drive(input bit want, input logic [1:0] id, output bit sent);
    logic [39:0] p;
    sent = 1'b0;
    response_in.valid = 1'b0;
    if (want && ready === 1'b1) begin
      p[39:34] = 6'($urandom);
      p[33:32] = id;
      p[31:0]  = $urandom;
      response_in.payload = p;
      response_in.valid   = 1'b1;
      sent = 1'b1;
      if (int'(id) < N) begin
        exp_q[id].push_back(p);
        iss_q[id].push_back(cyc);
      end else begin
        drop_model = (drop_model == 16'hFFFF) ? 16'hFFFF : drop_model + 16'd1;
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    bit s;
    for (int k = 0; k < n; k++) drive(1'b0, 2'd0, s);
  endtask

  function automatic int left_total();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
  endfunction

  task automatic drain(input string tag);
    int k = 0;
    for (int i = 0; i < N; i++) rd_in[i].rd_en = 1'b1;
    while (left_total() != 0 && k < 300) begin
      idle(1);
      k++;
    end
    check_eq(tag, 64'(left_total()), 64'd0);
  endtask

  task automatic wait_setup(input string tag);
    int k = 0;
    while (setup !== 1'b0 && k < 20) begin
      idle(1);
      k++;
    end
    check_eq(tag, 64'(setup), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = resp_out[i].valid;
    check_eq({tag, "_valid"}, 64'(v), 64'd0);
    check_eq({tag, "_status"}, 64'(status_out), 64'd0);
    check_eq({tag, "_ready"}, 64'(ready), 64'd0);
    check_eq({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    check_eq({tag, "_error"}, 64'(error), 64'd0);
    check_eq({tag, "_setup"}, 64'(setup), 64'd1);
  endtask

  initial begin
    bit          s;
    bit          fell;
    int          sent_n;
    int          k;
    int          total;
    logic [1:0]  alt;

    areset      = 1'b1;
    response_in = '0;
    rd_in       = '0;
    repeat (3) tick();
    check_reset("por");
    areset = 1'b0;
    wait_setup("por_setup_fall");
    idle(1);
    check_eq("por_ready", 64'(ready), 64'd1);
    check_eq("por_empty", 64'({status_out[2].empty, status_out[1].empty, status_out[0].empty}), 64'd7);

    // Routing and latency: one packet to each receiver back to back.
    for (int i = 0; i < N; i++) rd_in[i].rd_en = 1'b1;
    idle(2);
    lat_chk = 1'b1;
    for (int i = 0; i < N; i++) drive(1'b1, 2'(i), s);
    idle(8);
    lat_chk = 1'b0;
    check_eq("route_left", 64'(left_total()), 64'd0);

    // Backpressure: receiver 2 stalled while 20 packets target it.
    rd_in[2].rd_en = 1'b0;
    idle(2);
    sent_n = 0;
    fell   = 1'b0;
    k      = 0;
    while (sent_n < 20 && k < 400) begin
      if (!fell && ready === 1'b0) begin
        fell = 1'b1;
        check_eq("sent_at_ready_fall", 64'(sent_n), 64'(THRESH + 3));
        check_eq("prog_full2", 64'(status_out[2].prog_full), 64'd1);
      end
      if (k == 59) check_eq("stalled_not_full", 64'(status_out[2].full), 64'd0);
      if (k == 60) rd_in[2].rd_en = 1'b1;
      drive(1'b1, 2'd2, s);
      if (s) sent_n++;
      k++;
    end
    check_eq("ready_fell", 64'(fell), 64'd1);
    check_eq("bp_sent", 64'(sent_n), 64'd20);
    drain("bp_drain");

    // Out-of-range id is dropped and counted; counter saturates.
    drive(1'b1, 2'd3, s);
    idle(6);
    check_eq("drop_one", 64'(drop_cnt), 64'(drop_model));
    check_eq("error_set", 64'(error), 64'd1);
    for (int j = 0; j < 65540; j++) drive(1'b1, 2'd3, s);
    idle(6);
    check_eq("drop_saturate", 64'(drop_cnt), 64'(drop_model));
    check_eq("error_sticky", 64'(error), 64'd1);

    // Alternating ids at full rate with random receiver pops.
    delivered = 0;
    total     = 0;
    alt       = 2'd0;
    for (int j = 0; j < 400; j++) begin
      for (int i = 0; i < N; i++) rd_in[i].rd_en = 1'($urandom_range(0, 1));
      drive(1'b1, alt, s);
      if (s) begin
        total++;
        alt = 2'd1 - alt;
      end
    end
    drain("rand_drain");
    idle(4);
    check_eq("rand_delivered", 64'(delivered), 64'(total));

    // Reset with packets queued: everything discarded.
    for (int i = 0; i < N; i++) rd_in[i].rd_en = 1'b0;
    for (int j = 0; j < 5; j++) drive(1'b1, 2'd0, s);
    idle(6);
    check_eq("queued_not_empty", 64'(status_out[0].empty), 64'd0);
    areset = 1'b1;
    #2;
    check_reset("midrst");
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      iss_q[i].delete();
    end
    drop_model = 16'h0000;
    idle(2);
    areset = 1'b0;
    check_eq("setup_at_release", 64'(setup), 64'd1);
    wait_setup("midrst_setup_fall");
    idle(1);
    check_eq("midrst_ready", 64'(ready), 64'd1);
    check_eq("midrst_drop", 64'(drop_cnt), 64'(drop_model));
    for (int i = 0; i < N; i++) rd_in[i].rd_en = 1'b1;
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
